// File: rtl/id_verify_pkg.sv
// Shared constants for the ID digit verifier: the reference ID, the FSM
// encoding and a helper that decodes a 1-based digit position.
package id_verify_pkg;

  localparam int NUM_DIGITS = 5;

  localparam logic [3:0] ID_D1 = 4'd2;
  localparam logic [3:0] ID_D2 = 4'd0;
  localparam logic [3:0] ID_D3 = 4'd4;
  localparam logic [3:0] ID_D4 = 4'd7;
  localparam logic [3:0] ID_D5 = 4'd1;

  // Slot 0 holds position 1.
  localparam logic [NUM_DIGITS-1:0][3:0] ID_DIGITS = {ID_D5, ID_D4, ID_D3, ID_D2, ID_D1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // One-hot slot select for position 1..5; zero for anything else.
  function automatic logic [NUM_DIGITS-1:0] slot_sel(input logic [3:0] idx);
    case (idx)
      4'd1:    slot_sel = 5'b00001;
      4'd2:    slot_sel = 5'b00010;
      4'd3:    slot_sel = 5'b00100;
      4'd4:    slot_sel = 5'b01000;
      4'd5:    slot_sel = 5'b10000;
      default: slot_sel = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/id_digit_verify_lockout_timer.sv
// Lockout down-counter: load the duration, count down while enabled,
// done is asserted during the last counted cycle.
module lockout_timer #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_load,
  input  logic i_count,
  output logic o_done
);

  localparam logic [15:0] LOAD_VAL = 16'(LOCK_CYCLES);

  logic [15:0] r_cnt;

  // Down-counter; stops at zero so a stray count enable is harmless.
  always_ff @(posedge Clk) begin
    if (!Reset)                     r_cnt <= '0;
    else if (i_load)                r_cnt <= LOAD_VAL;
    else if (i_count && r_cnt != 0) r_cnt <= r_cnt - 16'd1;
  end

  assign o_done = (r_cnt == 16'd1);

endmodule

// File: rtl/id_digit_verify.sv
// Five-digit ID entry and verification with attempt counting and a timed
// lockout. All outputs come from registers or decoded registered state.
module id_digit_verify
  import id_verify_pkg::*;
#(
  parameter int MAX_ATTEMPTS = 3,
  parameter int LOCK_CYCLES  = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [3:0]            DigitIndex,
  input  logic [3:0]            DigitValue,
  input  logic                  Enter,
  input  logic                  Clear,
  output logic [NUM_DIGITS-1:0] EnteredMask,
  output logic                  Unlocked,
  output logic                  Failed,
  output logic                  Locked,
  output logic [1:0]            AttemptCount
);

  localparam logic [1:0] MAX_A = 2'(MAX_ATTEMPTS);

  state_t                       r_state, w_state_nxt;
  logic [NUM_DIGITS-1:0][3:0]   r_slot;
  logic [NUM_DIGITS-1:0]        r_mask;
  logic [1:0]                   r_att;

  logic [NUM_DIGITS-1:0]        w_sel;
  logic [NUM_DIGITS-1:0]        w_mask_wr;
  logic                         w_wr;
  logic                         w_load, w_count, w_done;

  assign w_sel     = slot_sel(DigitIndex);
  // Clear beats Enter; out-of-range position or value is dropped.
  assign w_wr      = (r_state == ST_IDLE) && Enter && !Clear &&
                     (w_sel != '0) && (DigitValue <= 4'd9);
  assign w_mask_wr = r_mask | w_sel;

  lockout_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
    .Clk     (Clk),
    .Reset   (Reset),
    .i_load  (w_load),
    .i_count (w_count),
    .o_done  (w_done)
  );

  // State register.
  always_ff @(posedge Clk) begin
    if (!Reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state decode and timer control.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_count     = 1'b0;
    case (r_state)
      ST_IDLE:    if (w_wr && w_mask_wr == '1) w_state_nxt = ST_CHECK;
      ST_CHECK:   w_state_nxt = (r_slot == ID_DIGITS) ? ST_PASS : ST_FAIL;
      ST_PASS:    if (Clear) w_state_nxt = ST_IDLE;
      ST_FAIL: begin
        // r_att already holds the incremented count here.
        if (r_att == MAX_A) begin
          w_state_nxt = ST_LOCKOUT;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_LOCKOUT: begin
        w_count = 1'b1;
        if (w_done) w_state_nxt = ST_IDLE;
      end
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // Digit slots, entry mask and attempt counter.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_slot <= '0;
      r_mask <= '0;
      r_att  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Clear) begin
            r_mask <= '0;
          end else if (w_wr) begin
            r_mask <= w_mask_wr;
            for (int i = 0; i < NUM_DIGITS; i++)
              if (w_sel[i]) r_slot[i] <= DigitValue;
          end
        end
        ST_CHECK: begin
          if (w_state_nxt == ST_FAIL) begin
            r_mask <= '0;
            r_att  <= (r_att == 2'd3) ? 2'd3 : r_att + 2'd1;
          end
        end
        ST_PASS: begin
          if (Clear) begin
            r_mask <= '0;
            r_att  <= '0;
          end
        end
        ST_LOCKOUT: begin
          if (w_done) begin
            r_mask <= '0;
            r_att  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign EnteredMask  = r_mask;
  assign AttemptCount = r_att;
  assign Unlocked     = (r_state == ST_PASS);
  assign Failed       = (r_state == ST_FAIL);
  assign Locked       = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_id_digit_verify.sv
// Self-checking bench: a behavioural model pushes the expected post-edge
// outputs to a queue for every driven cycle; they are popped and compared
// once the edge has happened.
module tb_id_digit_verify;

  localparam int MAXA = 3;
  localparam int LCK  = 16;

  logic       Clk = 1'b0;
  logic       Reset, Enter, Clear;
  logic [3:0] DigitIndex, DigitValue;
  logic [4:0] EnteredMask;
  logic       Unlocked, Failed, Locked;
  logic [1:0] AttemptCount;

  id_digit_verify #(.MAX_ATTEMPTS(MAXA), .LOCK_CYCLES(LCK)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DigitIndex   (DigitIndex),
    .DigitValue   (DigitValue),
    .Enter        (Enter),
    .Clear        (Clear),
    .EnteredMask  (EnteredMask),
    .Unlocked     (Unlocked),
    .Failed       (Failed),
    .Locked       (Locked),
    .AttemptCount (AttemptCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] mask;
    logic       unl, fl, lk;
    logic [1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   errs = 0, checks = 0, lock_seen = 0;

  // Model state: 0 idle, 1 check, 2 pass, 3 fail, 4 lockout.
  int         m_st, m_tmr, m_cnt;
  logic [4:0] m_mask;
  int         m_slot[5];
  int         id[5] = '{2, 0, 4, 7, 1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic rst, input logic en, input int idx, input int val, input logic clr);
    exp_t e;
    bit   ok;
    if (!rst) begin
      m_st = 0; m_tmr = 0; m_cnt = 0; m_mask = '0;
      for (int i = 0; i < 5; i++) m_slot[i] = 0;
    end else begin
      case (m_st)
        0: begin
          if (clr) m_mask = '0;
          else if (en && idx >= 1 && idx <= 5 && val <= 9) begin
            m_slot[idx-1] = val;
            m_mask[idx-1] = 1'b1;
            if (m_mask == 5'h1f) m_st = 1;
          end
        end
        1: begin
          ok = 1;
          for (int i = 0; i < 5; i++) if (m_slot[i] != id[i]) ok = 0;
          if (ok) m_st = 2;
          else begin
            m_st = 3; m_mask = '0;
            if (m_cnt < 3) m_cnt++;
          end
        end
        2: if (clr) begin m_st = 0; m_mask = '0; m_cnt = 0; end
        3: if (m_cnt == MAXA) begin m_st = 4; m_tmr = LCK; end else m_st = 0;
        4: begin
          m_tmr--;
          if (m_tmr == 0) begin m_st = 0; m_cnt = 0; m_mask = '0; end
        end
        default: m_st = 0;
      endcase
    end
    e.mask = m_mask;
    e.unl  = (m_st == 2);
    e.fl   = (m_st == 3);
    e.lk   = (m_st == 4);
    e.cnt  = 2'(m_cnt);
    sbq.push_back(e);
  endtask

  // Drive one cycle from the falling edge, compare just after the rising edge.
  task automatic cyc(input logic rst, input logic en, input int idx, input int val, input logic clr);
    exp_t e;
    Reset = rst; Enter = en; Clear = clr;
    DigitIndex = 4'(idx); DigitValue = 4'(val);
    model_step(rst, en, idx, val, clr);
    @(posedge Clk);
    #1;
    e = sbq.pop_front();
    chk("mask",     32'(EnteredMask),  32'(e.mask));
    chk("unlocked", 32'(Unlocked),     32'(e.unl));
    chk("failed",   32'(Failed),       32'(e.fl));
    chk("locked",   32'(Locked),       32'(e.lk));
    chk("attempts", 32'(AttemptCount), 32'(e.cnt));
    if (Locked) lock_seen++;
    @(negedge Clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0);
  endtask

  task automatic code5(input int a, input int b, input int c, input int d, input int f);
    cyc(1, 1, 1, a, 0);
    cyc(1, 1, 2, b, 0);
    cyc(1, 1, 3, c, 0);
    cyc(1, 1, 4, d, 0);
    cyc(1, 1, 5, f, 0);
  endtask

  initial begin
    Reset = 1'b0; Enter = 1'b0; Clear = 1'b0; DigitIndex = '0; DigitValue = '0;
    m_st = 0; m_tmr = 0; m_cnt = 0; m_mask = '0;
    @(negedge Clk);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 1, 2, 1);
    chk("rst_state", {EnteredMask, Unlocked, Failed, Locked, AttemptCount}, 0);

    // Correct code: CHECK after 5th edge, PASS one edge later, Clear leaves.
    code5(2, 0, 4, 7, 1);
    chk("mask_full", 32'(EnteredMask), 32'h1f);
    chk("unl_not_yet", 32'(Unlocked), 0);
    idle(1);
    chk("unl_2edges", 32'(Unlocked), 1);
    idle(2);
    cyc(1, 0, 0, 0, 1);
    chk("unl_clear", 32'(Unlocked), 0);

    // Wrong last digit: one Failed pulse, count 1.
    code5(2, 0, 4, 7, 9);
    idle(1);
    chk("fail_pulse", 32'(Failed), 1);
    idle(2);
    chk("cnt1", 32'(AttemptCount), 1);

    // Invalid writes ignored; slot 3 overwritten with a wrong digit.
    cyc(1, 1, 0, 5, 0);
    cyc(1, 1, 6, 5, 0);
    cyc(1, 1, 1, 12, 0);
    chk("mask_inval", 32'(EnteredMask), 0);
    cyc(1, 1, 3, 4, 0);
    cyc(1, 1, 3, 5, 0);
    cyc(1, 1, 1, 2, 0);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 1, 4, 7, 0);
    cyc(1, 1, 5, 1, 0);
    idle(3);
    chk("cnt2", 32'(AttemptCount), 2);

    // Clear wins over Enter; Clear in IDLE keeps the count.
    cyc(1, 1, 1, 2, 1);
    cyc(1, 1, 2, 0, 0);
    cyc(1, 0, 0, 0, 1);
    chk("clr_keep_cnt", 32'(AttemptCount), 2);

    // Third failure: lockout for LCK cycles, Enter ignored meanwhile.
    lock_seen = 0;
    code5(9, 9, 9, 9, 9);
    for (int i = 0; i < LCK + 4; i++) cyc(1, 1, 1, 2, 0);
    chk("lock_len", 32'(lock_seen), 32'(LCK));
    chk("cnt_after_lock", 32'(AttemptCount), 0);
    cyc(1, 0, 0, 0, 1);

    // Clear ignored in CHECK.
    code5(2, 0, 4, 7, 1);
    cyc(1, 0, 0, 0, 1);
    chk("clr_in_check", 32'(Unlocked), 1);
    cyc(1, 0, 0, 0, 1);

    // Reset mid-CHECK.
    code5(2, 0, 4, 7, 1);
    cyc(0, 0, 0, 0, 0);
    idle(2);
    chk("rst_check", 32'(Unlocked), 0);

    // Reset during lockout cycle 5.
    for (int k = 0; k < 3; k++) begin
      code5(1, 1, 1, 1, 1);
      idle(2);
    end
    idle(3);
    chk("in_lock", 32'(Locked), 1);
    cyc(0, 1, 1, 2, 1);
    chk("rst_lock", {EnteredMask, Unlocked, Failed, Locked, AttemptCount}, 0);
    idle(3);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/id_digit_verify.md
ID_DIGIT_VERIFY -- requirements
Module: id_digit_verify

Interface
REQ-001 The block SHALL have parameter MAX_ATTEMPTS, default 3, failed checks before lockout (1..3).
REQ-002 The block SHALL have parameter LOCK_CYCLES, default 16, lockout duration in clock cycles (>=1, fits 16 bits).
REQ-003 The block SHALL have port Clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port Reset  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port DigitIndex  input  4  digit position from the toggle counter, valid 1..5.
REQ-006 The block SHALL have port DigitValue  input  4  digit entered, valid 0..9.
REQ-007 The block SHALL have port Enter  input  1  one-cycle strobe: write DigitValue at DigitIndex.
REQ-008 The block SHALL have port Clear  input  1  one-cycle strobe: abandon entry or leave PASS.
REQ-009 The block SHALL have port EnteredMask  output  5  bit i-1 set when position i holds a digit.
REQ-010 The block SHALL have port Unlocked  output  1  high while in PASS.
REQ-011 The block SHALL have port Failed  output  1  one-cycle pulse on a mismatch.
REQ-012 The block SHALL have port Locked  output  1  high while in LOCKOUT.
REQ-013 The block SHALL have port AttemptCount  output  2  failed checks since last pass, reset or lockout exit.

Function
REQ-014 FSM states SHALL be IDLE, CHECK, PASS, FAIL, LOCKOUT.
REQ-015 IDLE + Enter, DigitIndex 1..5, DigitValue <=9: SHALL store digit in slot, set mask bit; rewriting a filled slot overwrites it.
REQ-016 Enter with DigitIndex 0 or >5, or DigitValue >9, SHALL be ignored (no slot or mask change).
REQ-017 Edge where a write makes the mask 5'b11111 SHALL move IDLE->CHECK; Enter in every other state SHALL be ignored.
REQ-018 CHECK SHALL last one cycle: all five slots equal the package ID digits -> PASS; else -> FAIL.
REQ-019 Unlocked SHALL be high starting the cycle after CHECK, i.e. two edges after the completing Enter.
REQ-020 FAIL SHALL last one cycle with Failed=1, clear mask, increment AttemptCount (saturating at 3).
REQ-021 From FAIL: new count == MAX_ATTEMPTS -> LOCKOUT; else -> IDLE.
REQ-022 LOCKOUT SHALL hold Locked=1 for exactly LOCK_CYCLES cycles, then -> IDLE with AttemptCount=0, mask=0.
REQ-023 PASS SHALL hold until Clear, then -> IDLE with mask=0, AttemptCount=0.
REQ-024 Clear in IDLE SHALL zero mask only (AttemptCount kept); Clear SHALL be ignored in CHECK, FAIL, LOCKOUT.
REQ-025 Clear and Enter in the same IDLE cycle: Clear SHALL win, no digit stored.
REQ-026 Outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-027 Reset==0 at a rising edge SHALL force IDLE, slots=0, mask=0, AttemptCount=0, Unlocked=0, Failed=0, Locked=0, lockout timer=0.
REQ-028 Reset SHALL take priority over Enter and Clear in every state, including mid-LOCKOUT and mid-CHECK.

Structure
REQ-029 Shared package id_verify_pkg SHALL hold the five ID digits (ID_D1..ID_D5), the FSM state encoding and a NUM_DIGITS=5 constant.
REQ-030 The lockout down-counter SHALL be sub-module lockout_timer (load, count, done), instantiated once.

Verification (package ID = 2,0,4,7,1; defaults)
REQ-031 Enter (1,2),(2,0),(3,4),(4,7),(5,1) -> mask 11111, CHECK next cycle, Unlocked=1 two edges after 5th Enter; Clear -> Unlocked=0, AttemptCount=0.
REQ-032 Enter 2,0,4,7,9 -> one-cycle Failed, AttemptCount=1, mask=0, back in IDLE.
REQ-033 Three wrong entries -> AttemptCount=3, Locked=1 for exactly 16 cycles, Enter ignored meanwhile; then IDLE, AttemptCount=0.
REQ-034 Enter at index 0, index 6, value 12 -> mask stays 0; (3,4) then (3,5) then rest correct except slot 3 -> Failed.
REQ-035 Clear with Enter same cycle -> no store; Reset low during LOCKOUT cycle 5 -> all outputs 0 next edge.
